// File: rtl/control_sequencer.sv
// control_sequencer: microprogrammed control unit for the ARC-style datapath.
// Holds the current microword in the MIR, drives the datapath fields from it,
// latches ALU flags into the PSR and selects the next control store address
// (sequential, conditional jump or opcode decode), stalling on slow memory.
module control_sequencer #(
   parameter int unsigned DATAWIDTH_MIR_DIRECTION = 6,
   parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
   parameter int unsigned DATAWIDTH_DECODEROP     = 8,
   parameter int unsigned DATAWIDTH_CS_ADDRESS    = 11,
   parameter int unsigned DATAWIDTH_MICROWORD     = 41
) (
   input  logic                               CONTROL_SEQUENCER_CLOCK_50,
   input  logic                               CONTROL_SEQUENCER_ResetInHigh_In,
   input  logic [DATAWIDTH_MICROWORD-1:0]     CONTROL_SEQUENCER_Microword_InBus,
   output logic [DATAWIDTH_CS_ADDRESS-1:0]    CONTROL_SEQUENCER_CSAddress_OutBus,
   input  logic [DATAWIDTH_DECODEROP-1:0]     CONTROL_SEQUENCER_DecodeOP_InBus,
   input  logic                               CONTROL_SEQUENCER_IR13_In,
   input  logic                               CONTROL_SEQUENCER_FlagNegative_In,
   input  logic                               CONTROL_SEQUENCER_FlagZero_In,
   input  logic                               CONTROL_SEQUENCER_FlagOverflow_In,
   input  logic                               CONTROL_SEQUENCER_FlagCarry_In,
   input  logic                               CONTROL_SEQUENCER_MemReady_In,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_SEQUENCER_DirA_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_SEQUENCER_DirB_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_SEQUENCER_DirC_OutBus,
   output logic                               CONTROL_SEQUENCER_SelectA_Out,
   output logic                               CONTROL_SEQUENCER_SelectB_Out,
   output logic                               CONTROL_SEQUENCER_SelectC_Out,
   output logic [DATAWIDTH_ALU_SELECTION-1:0] CONTROL_SEQUENCER_ALUOperation_OutBus,
   output logic                               CONTROL_SEQUENCER_RD_Out,
   output logic                               CONTROL_SEQUENCER_WR_Out,
   output logic [3:0]                         CONTROL_SEQUENCER_PSR_OutBus
);

   // MIR field positions, packed from JADDR at bit 0 upward to A at the top.
   localparam int unsigned COND_W   = 3;
   localparam int unsigned LSB_COND = DATAWIDTH_CS_ADDRESS;
   localparam int unsigned LSB_ALU  = LSB_COND + COND_W;
   localparam int unsigned BIT_WR   = LSB_ALU + DATAWIDTH_ALU_SELECTION;
   localparam int unsigned BIT_RD   = BIT_WR + 1;
   localparam int unsigned BIT_CMUX = BIT_RD + 1;
   localparam int unsigned LSB_C    = BIT_CMUX + 1;
   localparam int unsigned BIT_BMUX = LSB_C + DATAWIDTH_MIR_DIRECTION;
   localparam int unsigned LSB_B    = BIT_BMUX + 1;
   localparam int unsigned BIT_AMUX = LSB_B + DATAWIDTH_MIR_DIRECTION;
   localparam int unsigned LSB_A    = BIT_AMUX + 1;

   typedef logic [DATAWIDTH_CS_ADDRESS-1:0] cs_addr_t;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_RUN,
      ST_STALL
   } state_t;

   state_t                           state_q, state_d;
   logic [DATAWIDTH_MICROWORD-1:0]   mir_q, mir_d;
   cs_addr_t                         upc_q, upc_d;
   logic [3:0]                       psr_q, psr_d;

   logic [DATAWIDTH_MIR_DIRECTION-1:0] mir_a, mir_b, mir_c;
   logic                               mir_amux, mir_bmux, mir_cmux;
   logic                               mir_rd, mir_wr;
   logic [DATAWIDTH_ALU_SELECTION-1:0] mir_alu;
   logic [COND_W-1:0]                  mir_cond;
   cs_addr_t                           mir_jaddr;

   cs_addr_t upc_inc;
   cs_addr_t decode_addr;
   cs_addr_t next_addr;
   logic     branch_taken;
   logic     mem_busy;
   logic     alu_sets_cc;
   logic     write_en;
   logic [3:0] flags_in;

   // Split the MIR into its named fields.
   always_comb begin
      mir_a     = mir_q[LSB_A +: DATAWIDTH_MIR_DIRECTION];
      mir_amux  = mir_q[BIT_AMUX];
      mir_b     = mir_q[LSB_B +: DATAWIDTH_MIR_DIRECTION];
      mir_bmux  = mir_q[BIT_BMUX];
      mir_c     = mir_q[LSB_C +: DATAWIDTH_MIR_DIRECTION];
      mir_cmux  = mir_q[BIT_CMUX];
      mir_rd    = mir_q[BIT_RD];
      mir_wr    = mir_q[BIT_WR];
      mir_alu   = mir_q[LSB_ALU +: DATAWIDTH_ALU_SELECTION];
      mir_cond  = mir_q[LSB_COND +: COND_W];
      mir_jaddr = mir_q[DATAWIDTH_CS_ADDRESS-1:0];
   end

   // Next microaddress: branch conditions test the registered PSR.
   always_comb begin
      upc_inc      = upc_q + 1'b1;
      decode_addr  = cs_addr_t'({1'b1, CONTROL_SEQUENCER_DecodeOP_InBus, 2'b00});
      branch_taken = 1'b0;
      case (mir_cond)
         3'd1:    branch_taken = psr_q[3];
         3'd2:    branch_taken = psr_q[2];
         3'd3:    branch_taken = psr_q[1];
         3'd4:    branch_taken = psr_q[0];
         3'd5:    branch_taken = CONTROL_SEQUENCER_IR13_In;
         3'd6:    branch_taken = 1'b1;
         default: branch_taken = 1'b0;
      endcase
      if (mir_cond == 3'd7) begin
         next_addr = decode_addr;
      end else if (branch_taken) begin
         next_addr = mir_jaddr;
      end else begin
         next_addr = upc_inc;
      end
   end

   // Memory handshake and condition-code qualifiers.
   always_comb begin
      mem_busy    = (mir_rd | mir_wr) & ~CONTROL_SEQUENCER_MemReady_In;
      alu_sets_cc = (mir_alu[DATAWIDTH_ALU_SELECTION-1:2] == '0);
      flags_in    = {CONTROL_SEQUENCER_FlagNegative_In, CONTROL_SEQUENCER_FlagZero_In,
                     CONTROL_SEQUENCER_FlagOverflow_In, CONTROL_SEQUENCER_FlagCarry_In};
   end

   // Sequencer next state: fill, run, or hold on an unfinished memory access.
   always_comb begin
      state_d  = state_q;
      mir_d    = mir_q;
      upc_d    = upc_q;
      psr_d    = psr_q;
      write_en = 1'b0;
      CONTROL_SEQUENCER_CSAddress_OutBus = '0;
      case (state_q)
         ST_FILL: begin
            CONTROL_SEQUENCER_CSAddress_OutBus = '0;
            mir_d   = CONTROL_SEQUENCER_Microword_InBus;
            upc_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN, ST_STALL: begin
            // A busy cycle re-presents the current address; the completing
            // stall cycle advances exactly as a normal run cycle would.
            if (mem_busy) begin
               CONTROL_SEQUENCER_CSAddress_OutBus = upc_q;
               state_d = ST_STALL;
            end else begin
               CONTROL_SEQUENCER_CSAddress_OutBus = next_addr;
               mir_d    = CONTROL_SEQUENCER_Microword_InBus;
               upc_d    = next_addr;
               write_en = 1'b1;
               state_d  = ST_RUN;
               if (alu_sets_cc) begin
                  psr_d = flags_in;
               end
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // State, MIR, uPC and PSR registers with synchronous reset.
   always_ff @(posedge CONTROL_SEQUENCER_CLOCK_50) begin
      if (CONTROL_SEQUENCER_ResetInHigh_In) begin
         state_q <= ST_FILL;
         mir_q   <= '0;
         upc_q   <= '0;
         psr_q   <= '0;
      end else begin
         state_q <= state_d;
         mir_q   <= mir_d;
         upc_q   <= upc_d;
         psr_q   <= psr_d;
      end
   end

   // Datapath drive; register writes are blocked unless the cycle advances.
   always_comb begin
      CONTROL_SEQUENCER_DirA_OutBus         = mir_a;
      CONTROL_SEQUENCER_SelectA_Out         = mir_amux;
      CONTROL_SEQUENCER_DirB_OutBus         = mir_b;
      CONTROL_SEQUENCER_SelectB_Out         = mir_bmux;
      CONTROL_SEQUENCER_DirC_OutBus         = write_en ? mir_c : '0;
      CONTROL_SEQUENCER_SelectC_Out         = write_en & mir_cmux;
      CONTROL_SEQUENCER_ALUOperation_OutBus = mir_alu;
      CONTROL_SEQUENCER_RD_Out              = mir_rd;
      CONTROL_SEQUENCER_WR_Out              = mir_wr;
      CONTROL_SEQUENCER_PSR_OutBus          = psr_q;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a cycle-level behavioural model
// plus directed literal expectations drawn from the microcode scenarios.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [40:0] mword;
   logic [10:0] csaddr;
   logic [7:0]  op = 8'h00;
   logic        ir13 = 1'b0;
   logic        fn = 1'b0, fz = 1'b0, fv = 1'b0, fc = 1'b0;
   logic        mrdy = 1'b1;
   logic [5:0]  dira, dirb, dirc;
   logic        sela, selb, selc;
   logic [3:0]  alu, psr;
   logic        rd, wr;

   logic [40:0] cs [0:2047];

   int n_chk  = 0;
   int n_fail = 0;

   assign mword = cs[csaddr];

   always #5 clk = ~clk;

   control_sequencer #(
      .DATAWIDTH_MIR_DIRECTION(6),
      .DATAWIDTH_ALU_SELECTION(4),
      .DATAWIDTH_DECODEROP(8),
      .DATAWIDTH_CS_ADDRESS(11),
      .DATAWIDTH_MICROWORD(41)
   ) dut (
      .CONTROL_SEQUENCER_CLOCK_50(clk),
      .CONTROL_SEQUENCER_ResetInHigh_In(rst),
      .CONTROL_SEQUENCER_Microword_InBus(mword),
      .CONTROL_SEQUENCER_CSAddress_OutBus(csaddr),
      .CONTROL_SEQUENCER_DecodeOP_InBus(op),
      .CONTROL_SEQUENCER_IR13_In(ir13),
      .CONTROL_SEQUENCER_FlagNegative_In(fn),
      .CONTROL_SEQUENCER_FlagZero_In(fz),
      .CONTROL_SEQUENCER_FlagOverflow_In(fv),
      .CONTROL_SEQUENCER_FlagCarry_In(fc),
      .CONTROL_SEQUENCER_MemReady_In(mrdy),
      .CONTROL_SEQUENCER_DirA_OutBus(dira),
      .CONTROL_SEQUENCER_DirB_OutBus(dirb),
      .CONTROL_SEQUENCER_DirC_OutBus(dirc),
      .CONTROL_SEQUENCER_SelectA_Out(sela),
      .CONTROL_SEQUENCER_SelectB_Out(selb),
      .CONTROL_SEQUENCER_SelectC_Out(selc),
      .CONTROL_SEQUENCER_ALUOperation_OutBus(alu),
      .CONTROL_SEQUENCER_RD_Out(rd),
      .CONTROL_SEQUENCER_WR_Out(wr),
      .CONTROL_SEQUENCER_PSR_OutBus(psr)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
      end
   endtask

   // Default word for address i: distinctive A/B fields, no writes, non-CC ALU op, sequential.
   function automatic logic [40:0] dflt(input int i);
      logic [10:0] a;
      a = 11'(i);
      return {a[5:0] ^ 6'h2A, a[0], a[10:5], a[1], 6'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 11'd0};
   endfunction

   // ---------------- behavioural model ----------------
   // m_valid: a microword has been fetched since reset; m_pc: its address;
   // m_w: the word itself; m_psr: latched flags.
   logic        m_valid = 1'b0;
   logic [10:0] m_pc = 11'd0;
   logic [40:0] m_w = '0;
   logic [3:0]  m_psr = 4'd0;
   logic [10:0] m_n;
   bit          chk_en = 1'b0;

   function logic [10:0] m_next();
      logic [10:0] j;
      logic [10:0] inc;
      j   = m_w[10:0];
      inc = m_pc + 11'd1;
      case (m_w[13:11])
         3'd0: return inc;
         3'd1: return m_psr[3] ? j : inc;
         3'd2: return m_psr[2] ? j : inc;
         3'd3: return m_psr[1] ? j : inc;
         3'd4: return m_psr[0] ? j : inc;
         3'd5: return ir13 ? j : inc;
         3'd6: return j;
         default: return {1'b1, op, 2'b00};
      endcase
   endfunction

   function bit m_busy();
      return m_valid && (m_w[19] || m_w[18]) && !mrdy;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b0;
         m_pc    = 11'd0;
         m_w     = '0;
         m_psr   = 4'd0;
      end else if (!m_valid) begin
         m_valid = 1'b1;
         m_pc    = 11'd0;
         m_w     = cs[0];
      end else if (!m_busy()) begin
         m_n = m_next();
         if (m_w[17:16] == 2'b00) m_psr = {fn, fz, fv, fc};
         m_pc = m_n;
         m_w  = cs[m_n];
      end
      chk_en = 1'b1;
   end

   logic        e_busy;
   logic [10:0] e_cs;

   always @(negedge clk) begin
      if (chk_en) begin
         e_busy = m_busy();
         e_cs   = !m_valid ? 11'd0 : (e_busy ? m_pc : m_next());
         check("m_csaddr", 32'(csaddr), 32'(e_cs));
         check("m_dira",   32'(dira),   32'(m_w[40:35]));
         check("m_sela",   32'(sela),   32'(m_w[34]));
         check("m_dirb",   32'(dirb),   32'(m_w[33:28]));
         check("m_selb",   32'(selb),   32'(m_w[27]));
         check("m_dirc",   32'(dirc),   e_busy ? 32'd0 : 32'(m_w[26:21]));
         check("m_selc",   32'(selc),   e_busy ? 32'd0 : 32'(m_w[20]));
         check("m_rd",     32'(rd),     32'(m_w[19]));
         check("m_wr",     32'(wr),     32'(m_w[18]));
         check("m_alu",    32'(alu),    32'(m_w[17:14]));
         check("m_psr",    32'(psr),    32'(m_psr));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the fill cycle, reset released.
   task automatic reset_seq();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [40:0] w;
   logic [10:0] t1_exp [6];
   logic [63:0] r;

   initial begin
      for (int i = 0; i < 2048; i++) cs[i] = dflt(i);
      tick();
      tick();
      #1;
      check("rst_cs",   32'(csaddr), 32'd0);
      check("rst_dira", 32'(dira),   32'd0);
      check("rst_rd",   32'(rd),     32'd0);
      check("rst_psr",  32'(psr),    32'd0);

      // Sequential fetch, jump to 2047, wrap to 0.
      w = dflt(3); w[13:11] = 3'd6; w[10:0] = 11'h7FF; cs[3] = w;
      reset_seq();
      #1;
      check("t1_fill_cs", 32'(csaddr), 32'd0);
      t1_exp = '{11'd1, 11'd2, 11'd3, 11'd2047, 11'd0, 11'd1};
      for (int k = 0; k < 6; k++) begin
         tick();
         #1;
         check("t1_seq", 32'(csaddr), 32'(t1_exp[k]));
      end
      check("t1_dira_w0", 32'(dira), 32'h2A);

      // ADDCC sets Z, next word branches on Z.
      cs[3] = dflt(3);
      w = dflt(5); w[17:14] = 4'b0011; cs[5] = w;
      w = dflt(6); w[13:11] = 3'd2; w[10:0] = 11'h100; cs[6] = w;
      fz = 1'b1;
      reset_seq();
      for (int k = 0; k < 7; k++) tick();
      #1;
      check("t2_psr", 32'(psr),    32'h4);
      check("t2_cs",  32'(csaddr), 32'h100);
      fz = 1'b0; fn = 1'b1;
      tick();
      #1;
      check("t2_psr_keep", 32'(psr), 32'h4);
      fn = 1'b0;
      reset_seq();
      for (int k = 0; k < 7; k++) tick();
      #1;
      check("t2b_cs",  32'(csaddr), 32'd7);
      check("t2b_psr", 32'(psr),    32'd0);

      // Opcode decode dispatch.
      w = dflt(1); w[13:11] = 3'd7; cs[1] = w;
      op = 8'h81;
      reset_seq();
      tick();
      tick();
      #1;
      check("t3_cs", 32'(csaddr), 32'h604);
      tick();
      #1;
      check("t3_dira", 32'(dira),   32'h2E);
      check("t3_dirb", 32'(dirb),   32'h30);
      check("t3_cs2",  32'(csaddr), 32'h605);

      // Read with three not-ready cycles.
      cs[1] = dflt(1);
      w = dflt(2); w[19] = 1'b1; w[26:21] = 6'd5; cs[2] = w;
      reset_seq();
      tick();
      tick();
      tick();
      mrdy = 1'b0;
      #1;
      check("t4_cs_s1",   32'(csaddr), 32'd2);
      check("t4_dirc_s1", 32'(dirc),   32'd0);
      check("t4_rd_s1",   32'(rd),     32'd1);
      tick();
      #1;
      check("t4_cs_s2",   32'(csaddr), 32'd2);
      check("t4_dirc_s2", 32'(dirc),   32'd0);
      check("t4_rd_s2",   32'(rd),     32'd1);
      tick();
      #1;
      check("t4_cs_s3",   32'(csaddr), 32'd2);
      check("t4_dirc_s3", 32'(dirc),   32'd0);
      tick();
      mrdy = 1'b1;
      #1;
      check("t4_cs_rdy",   32'(csaddr), 32'd3);
      check("t4_dirc_rdy", 32'(dirc),   32'd5);
      tick();
      #1;
      check("t4_cs_after", 32'(csaddr), 32'd4);
      check("t4_rd_after", 32'(rd),     32'd0);

      // Reset in the second stall cycle.
      reset_seq();
      tick();
      tick();
      tick();
      mrdy = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      #1;
      check("t5_cs",   32'(csaddr), 32'd0);
      check("t5_rd",   32'(rd),     32'd0);
      check("t5_dira", 32'(dira),   32'd0);
      check("t5_dirc", 32'(dirc),   32'd0);
      check("t5_alu",  32'(alu),    32'd0);
      rst = 1'b0;
      mrdy = 1'b1;
      tick();
      #1;
      check("t5_dira_w0", 32'(dira),   32'h2A);
      check("t5_cs_w0",   32'(csaddr), 32'd1);

      // IR13 branch, ORCC, C/V/N branches, write and stalled read with ADDCC.
      cs[2] = dflt(2);
      w = dflt(1);      w[13:11] = 3'd5; w[10:0] = 11'h050; cs[1] = w;
      w = dflt(11'h50); w[17:14] = 4'b0001; cs[11'h50] = w;
      w = dflt(11'h51); w[13:11] = 3'd4; w[10:0] = 11'h0A0; cs[11'h51] = w;
      w = dflt(11'hA0); w[13:11] = 3'd3; w[10:0] = 11'h7FF; cs[11'hA0] = w;
      w = dflt(11'hA1); w[13:11] = 3'd1; w[10:0] = 11'h300; cs[11'hA1] = w;
      w = dflt(11'h300); w[18] = 1'b1; w[26:21] = 6'd7; w[17:14] = 4'b0011; cs[11'h300] = w;
      w = dflt(11'h301); w[19] = 1'b1; w[17:14] = 4'b0011; cs[11'h301] = w;
      ir13 = 1'b1;
      reset_seq();
      tick();
      tick();
      #1;
      check("t6_ir13_taken", 32'(csaddr), 32'h050);
      fn = 1'b1; fz = 1'b0; fv = 1'b0; fc = 1'b1;
      tick();
      ir13 = 1'b0;
      #1;
      check("t6_orcc_cs",  32'(csaddr), 32'h051);
      check("t6_orcc_alu", 32'(alu),    32'h1);
      ir13 = 1'b1;
      tick();
      #1;
      check("t6_psr_orcc", 32'(psr),    32'h9);
      check("t6_c_taken",  32'(csaddr), 32'h0A0);
      ir13 = 1'b0;
      tick();
      #1;
      check("t6_v_untaken", 32'(csaddr), 32'h0A1);
      tick();
      #1;
      check("t6_n_taken", 32'(csaddr), 32'h300);
      tick();
      fn = 1'b0; fz = 1'b1; fv = 1'b1; fc = 1'b0;
      #1;
      check("t6_wr",      32'(wr),     32'd1);
      check("t6_dirc7",   32'(dirc),   32'd7);
      check("t6_wr_next", 32'(csaddr), 32'h301);
      tick();
      mrdy = 1'b0;
      fn = 1'b1; fz = 1'b0; fv = 1'b0;
      #1;
      check("t6_psr_addcc", 32'(psr),    32'h6);
      check("t6_rd_hold",   32'(csaddr), 32'h301);
      tick();
      #1;
      check("t6_psr_stall", 32'(psr), 32'h6);
      mrdy = 1'b1;
      tick();
      #1;
      check("t6_psr_done", 32'(psr),    32'h8);
      check("t6_cs_done",  32'(csaddr), 32'h303);
      fn = 1'b0;
      ir13 = 1'b0;
      reset_seq();
      tick();
      tick();
      #1;
      check("t6_ir13_untaken", 32'(csaddr), 32'd2);

      // Model-checked run over a scrambled control store with varying inputs.
      rst = 1'b1;
      tick();
      for (int i = 0; i < 2048; i++) begin
         r = {$urandom(), $urandom()};
         w = r[40:0];
         if ($urandom_range(0, 5) != 0) w[19:18] = 2'b00;
         cs[i] = w;
      end
      reset_seq();
      for (int k = 0; k < 400; k++) begin
         tick();
         fn   = 1'($urandom_range(0, 1));
         fz   = 1'($urandom_range(0, 1));
         fv   = 1'($urandom_range(0, 1));
         fc   = 1'($urandom_range(0, 1));
         ir13 = 1'($urandom_range(0, 1));
         op   = 8'($urandom_range(0, 255));
         mrdy = ($urandom_range(0, 2) != 0);
         rst  = (k == 200);
      end
      rst = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
